mem_access_unit: RTL and testbench

Memory access unit (MAU) for the RISC-V core. It is the consumer of the execute stage's address/data outputs for LOAD and STORE instructions. It drives a single-outstanding request/ready data-bus transaction and applies byte-lane steering and write strobes for stores. For loads it extracts, sign- or zero-extends, and writes back the data, and it stalls the pipeline until the bus completes.

---
 rtl/mau_defs.sv | 45 ++++
 rtl/mau_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_defs.sv
// Shared definitions for the memory access unit: funct3 codes, FSM state
// encodings and access-size decoding.
package mau_defs;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUS  = 2'd1,
        MAU_WB   = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mau_size_e;

    // Access width as seen by the alignment check. Loads and stores decode
    // funct3 differently: stores only special-case SB/SH (everything else
    // is a word), loads also recognise the unsigned byte/half variants.
    function automatic mau_size_e access_size(input logic [2:0] f3, input logic is_load);
        mau_size_e sz;
        sz = SZ_WORD;
        if (is_load) begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
        end else begin
            if (f3 == F3_SB)      sz = SZ_BYTE;
            else if (f3 == F3_SH) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load data alignment: selects the addressed byte/halfword from a bus word
// and sign- or zero-extends it according to funct3. Purely combinational so
// it can be shared with other read paths (e.g. a cache refill).
module mau_load_align
    import mau_defs::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        // addr_lo[0] is deliberately ignored: a halfword always comes from
        // one of the two naturally aligned lanes.
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: single-outstanding request/ready bus master for
// LOAD/STORE. Stores get lane-replicated data and byte strobes; loads are
// aligned/extended and written back with a one-cycle reg_wen.
// Optional feature macro: MAU_MISALIGN_CHECK_EN (misaligned-access detection
// and misalign_exc generation; when undefined every access is accepted and
// misalign_exc is constant 0).
module mem_access_unit
    import mau_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_toMAU,
    input  logic [31:0] data_toMAU,
    input  logic [2:0]  funct3,
    input  logic        riscv_LOAD,
    input  logic        riscv_STORE,
    input  logic [4:0]  rd_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_toReg,
    output logic [4:0]  rd_addr_out,
    output logic        reg_wen,
    output logic        mau_stall,
    output logic        misalign_exc
);

    mau_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_toReg_q, data_toReg_d;
    logic [4:0]  rd_addr_out_q, rd_addr_out_d;
    logic        reg_wen_q, reg_wen_d;
    logic        misalign_q, misalign_d;

    logic        can_accept;
    logic        access;
    logic        misaligned;
    logic        accept;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] load_data;

    assign access     = riscv_LOAD | riscv_STORE;
    assign can_accept = (state_q == MAU_IDLE) || (state_q == MAU_WB);

`ifdef MAU_MISALIGN_CHECK_EN
    mau_size_e size;
    // Alignment check against the decoded access width; LOAD wins when both
    // instruction flags are high.
    always_comb begin
        size       = access_size(funct3, riscv_LOAD);
        misaligned = ((size == SZ_HALF) && addr_toMAU[0]) ||
                     ((size == SZ_WORD) && (addr_toMAU[1:0] != 2'b00));
    end
`else
    assign misaligned = 1'b0;
`endif

    assign accept    = can_accept & access & ~misaligned;
    assign mau_stall = accept | ((state_q == MAU_BUS) & ~mem_ready);

    // Store lane steering and byte strobes
    always_comb begin
        case (funct3)
            F3_SB: begin
                st_wdata = {4{data_toMAU[7:0]}};
                st_wstrb = 4'b0001 << addr_toMAU[1:0];
            end
            F3_SH: begin
                st_wdata = {2{data_toMAU[15:0]}};
                st_wstrb = 4'b0011 << {addr_toMAU[1], 1'b0};
            end
            default: begin
                st_wdata = data_toMAU;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    mau_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (f3_q),
        .addr_lo   (off_q),
        .load_data (load_data)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        f3_d          = f3_q;
        off_d         = off_q;
        rd_d          = rd_q;
        data_toReg_d  = data_toReg_q;
        rd_addr_out_d = rd_addr_out_q;
        reg_wen_d     = 1'b0;
        misalign_d    = can_accept & access & misaligned;

        case (state_q)
            MAU_BUS: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = MAU_IDLE;
                    end else begin
                        state_d       = MAU_WB;
                        data_toReg_d  = load_data;
                        rd_addr_out_d = rd_q;
                        reg_wen_d     = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and WB both accept a new access
                if (accept) begin
                    state_d     = MAU_BUS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~riscv_LOAD;
                    mem_addr_d  = {addr_toMAU[31:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_wstrb_d = riscv_LOAD ? 4'b0000 : st_wstrb;
                    f3_d        = funct3;
                    off_d       = addr_toMAU[1:0];
                    rd_d        = rd_addr;
                end else begin
                    state_d   = MAU_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MAU_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_wstrb_q   <= 4'd0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            rd_q          <= 5'd0;
            data_toReg_q  <= 32'd0;
            rd_addr_out_q <= 5'd0;
            reg_wen_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            rd_q          <= rd_d;
            data_toReg_q  <= data_toReg_d;
            rd_addr_out_q <= rd_addr_out_d;
            reg_wen_q     <= reg_wen_d;
            misalign_q    <= misalign_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign data_toReg   = data_toReg_q;
    assign rd_addr_out  = rd_addr_out_q;
    assign reg_wen      = reg_wen_q;
    assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table-driven single accesses plus
// hand-written sequences for misalignment, reset during BUS and
// back-to-back load/store.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_toMAU;
    logic [31:0] data_toMAU;
    logic [2:0]  funct3;
    logic        riscv_LOAD;
    logic        riscv_STORE;
    logic [4:0]  rd_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] data_toReg;
    logic [4:0]  rd_addr_out;
    logic        reg_wen;
    logic        mau_stall;
    logic        misalign_exc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .addr_toMAU   (addr_toMAU),
        .data_toMAU   (data_toMAU),
        .funct3       (funct3),
        .riscv_LOAD   (riscv_LOAD),
        .riscv_STORE  (riscv_STORE),
        .rd_addr      (rd_addr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .data_toReg   (data_toReg),
        .rd_addr_out  (rd_addr_out),
        .reg_wen      (reg_wen),
        .mau_stall    (mau_stall),
        .misalign_exc (misalign_exc)
    );

    typedef struct {
        string       name;
        logic        is_load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          waits;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        riscv_LOAD  = 1'b0;
        riscv_STORE = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic present(input logic is_load, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd);
        riscv_LOAD  = is_load;
        riscv_STORE = ~is_load;
        funct3      = f3;
        addr_toMAU  = a;
        data_toMAU  = d;
        rd_addr     = rd;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] held;
        present(v.is_load, v.f3, v.addr, v.wdata, v.rd);
        #1;
        chk({v.name, " c0 stall"}, {31'd0, mau_stall}, 32'd1);
        tick();
        idle_inputs();
        chk({v.name, " req"},  {31'd0, mem_req}, 32'd1);
        chk({v.name, " we"},   {31'd0, mem_we}, {31'd0, ~v.is_load});
        chk({v.name, " addr"}, mem_addr, v.e_addr);
        chk({v.name, " strb"}, {28'd0, mem_wstrb}, {28'd0, v.e_strb});
        if (!v.is_load) chk({v.name, " wdata"}, mem_wdata, v.e_wdata);
        for (int w = 0; w < v.waits; w++) begin
            mem_ready = 1'b0;
            #1;
            chk({v.name, " wait stall"}, {31'd0, mau_stall}, 32'd1);
            chk({v.name, " wait req"},   {31'd0, mem_req}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        #1;
        chk({v.name, " ready stall"}, {31'd0, mau_stall}, 32'd0);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk({v.name, " req drop"}, {31'd0, mem_req}, 32'd0);
        if (v.is_load) begin
            chk({v.name, " reg_wen"}, {31'd0, reg_wen}, 32'd1);
            chk({v.name, " data"},    data_toReg, v.e_data);
            chk({v.name, " rd"},      {27'd0, rd_addr_out}, {27'd0, v.rd});
            held = data_toReg;
            tick();
            chk({v.name, " wen 1cyc"}, {31'd0, reg_wen}, 32'd0);
            chk({v.name, " data hold"}, data_toReg, v.e_data);
        end else begin
            chk({v.name, " st no wen"}, {31'd0, reg_wen}, 32'd0);
            tick();
        end
        $display("[TB] %s addr=0x%08h done", v.name, v.addr);
    endtask

    initial begin
        vecs[0]  = '{"SW",      1'b0, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 5'd0, 0,
                     32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        vecs[1]  = '{"SB",      1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 5'd0, 0,
                     32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0};
        vecs[2]  = '{"SH",      1'b0, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 5'd0, 1,
                     32'h0000_1000, 32'hBEEF_BEEF, 4'b1100, 32'h0};
        vecs[3]  = '{"SB1",     1'b0, 3'b000, 32'h0000_2001, 32'hFFFF_FF37, 32'h0, 5'd0, 0,
                     32'h0000_2000, 32'h3737_3737, 4'b0010, 32'h0};
        vecs[4]  = '{"S100asSW",1'b0, 3'b100, 32'h0000_3000, 32'h1122_3344, 32'h0, 5'd0, 0,
                     32'h0000_3000, 32'h1122_3344, 4'b1111, 32'h0};
        vecs[5]  = '{"LB",      1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 5'd5, 0,
                     32'h0000_2000, 32'h0, 4'b0000, 32'hFFFF_FF80};
        vecs[6]  = '{"LBU",     1'b1, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 5'd6, 0,
                     32'h0000_2000, 32'h0, 4'b0000, 32'h0000_0080};
        vecs[7]  = '{"LH",      1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 5'd9, 3,
                     32'h0000_2000, 32'h0, 4'b0000, 32'hFFFF_8001};
        vecs[8]  = '{"LHU",     1'b1, 3'b101, 32'h0000_2000, 32'h0, 32'h1111_F00D, 5'd10, 0,
                     32'h0000_2000, 32'h0, 4'b0000, 32'h0000_F00D};
        vecs[9]  = '{"LW",      1'b1, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 5'd31, 1,
                     32'h0000_2004, 32'h0, 4'b0000, 32'hCAFE_F00D};
        vecs[10] = '{"LB3",     1'b1, 3'b000, 32'h0000_2003, 32'h0, 32'h7F00_00FF, 5'd1, 0,
                     32'h0000_2000, 32'h0, 4'b0000, 32'h0000_007F};
        vecs[11] = '{"L011",    1'b1, 3'b011, 32'h0000_3000, 32'h0, 32'h89AB_CDEF, 5'd12, 0,
                     32'h0000_3000, 32'h0, 4'b0000, 32'h89AB_CDEF};

        reset = 1'b1;
        addr_toMAU = 32'h0; data_toMAU = 32'h0; funct3 = 3'd0; rd_addr = 5'd0;
        mem_rdata = 32'h0;
        idle_inputs();
        tick();
        tick();
        chk("rst mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr",  mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst data",      data_toReg, 32'd0);
        chk("rst rd",        {27'd0, rd_addr_out}, 32'd0);
        chk("rst wen",       {31'd0, reg_wen}, 32'd0);
        chk("rst misalign",  {31'd0, misalign_exc}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Misaligned LW at 0x2002
        present(1'b1, 3'b010, 32'h0000_2002, 32'h0, 5'd3);
        #1;
`ifdef MAU_MISALIGN_CHECK_EN
        chk("mis stall", {31'd0, mau_stall}, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("mis exc",    {31'd0, misalign_exc}, 32'd1);
        chk("mis no req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("mis exc 1cyc", {31'd0, misalign_exc}, 32'd0);
        chk("mis no req2",  {31'd0, mem_req}, 32'd0);
`else
        chk("unal stall", {31'd0, mau_stall}, 32'd1);
        tick();
        idle_inputs();
        chk("unal req",  {31'd0, mem_req}, 32'd1);
        chk("unal addr", mem_addr, 32'h0000_2000);
        chk("unal exc",  {31'd0, misalign_exc}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0123_4567;
        tick();
        mem_ready = 1'b0;
        chk("unal data", data_toReg, 32'h0123_4567);
        tick();
`endif
        $display("[TB] misaligned LW sequence done");

        // Reset while waiting in BUS
        present(1'b1, 3'b010, 32'h0000_5000, 32'h0, 5'd17);
        tick();
        idle_inputs();
        chk("rstbus req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rstbus req0", {31'd0, mem_req}, 32'd0);
        chk("rstbus wen0", {31'd0, reg_wen}, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ready = 1'b0;
        chk("rstbus late wen", {31'd0, reg_wen}, 32'd0);
        chk("rstbus late req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rstbus late wen2", {31'd0, reg_wen}, 32'd0);
        $display("[TB] reset during BUS sequence done");

        // LW then SW accepted in the LW writeback cycle
        present(1'b1, 3'b010, 32'h0000_4000, 32'h0, 5'd7);
        tick();
        idle_inputs();
        chk("b2b lw req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0055;
        tick();
        mem_ready = 1'b0;
        present(1'b0, 3'b010, 32'h0000_4004, 32'h0000_0099, 5'd0);
        #1;
        chk("b2b wb wen",   {31'd0, reg_wen}, 32'd1);
        chk("b2b wb data",  data_toReg, 32'h0000_0055);
        chk("b2b wb rd",    {27'd0, rd_addr_out}, 32'd7);
        chk("b2b wb stall", {31'd0, mau_stall}, 32'd1);
        tick();
        idle_inputs();
        chk("b2b sw req",   {31'd0, mem_req}, 32'd1);
        chk("b2b sw we",    {31'd0, mem_we}, 32'd1);
        chk("b2b sw addr",  mem_addr, 32'h0000_4004);
        chk("b2b sw wdata", mem_wdata, 32'h0000_0099);
        chk("b2b sw wen0",  {31'd0, reg_wen}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("b2b sw drop",  {31'd0, mem_req}, 32'd0);
        chk("b2b data hold", data_toReg, 32'h0000_0055);
        $display("[TB] back-to-back LW/SW sequence done");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
